// File: rtl/hazard_pkg.sv
// Shared stage numbering, forward-select encoding and scoreboard entry layout
// for the hazard scoreboard.
package hazard_pkg;

    localparam int ST_EX = 1;
    localparam int ST_ME = 2;
    localparam int ST_WB = 3;

    // fwd_sel value k picks the result sitting in stage k+1; 0 reads the register file
    localparam int FWD_RF = 0;
    localparam int FWD_ME = ST_ME - 1;
    localparam int FWD_WB = ST_WB - 1;

    // Entry fields are sized for pipelines up to 15 stages behind DE
    localparam int SB_W = 4;

    typedef struct packed {
        logic [SB_W-1:0] age;
        logic [SB_W-1:0] lat;
    } sb_entry_t;

    function automatic int fwd_from_age(input int age, input int depth);
        return (age >= 1 && age <= depth - 1) ? age : FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One architectural register's in-flight writer: stage age plus that writer's
// result latency. A new issue always replaces the older writer.
module sb_entry
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set,
    input  logic [SB_W-1:0] set_lat,
    output sb_entry_t       ent
);

    localparam logic [SB_W-1:0] AGE_RETIRE = SB_W'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent <= '0;
        end else if (set) begin
            ent.age <= SB_W'(ST_EX);
            ent.lat <= set_lat;
        end else if (ent.age == AGE_RETIRE) begin
            ent.age <= '0;
        end else if (ent.age != '0) begin
            ent.age <= ent.age + SB_W'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard beside decode: stalls DE on unforwardable operands
// and registers the EX operand forward selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int DEPTH = 3,
    parameter int AW    = $clog2(NREGS),
    parameter int SELW  = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic                      issue_wr,
    input  logic [AW-1:0]             issue_rd,
    input  logic [SELW-1:0]           issue_lat,
    input  logic                      flush,
    input  logic [NRD-1:0]            rs_used,
    input  logic [NRD-1:0][AW-1:0]    rs_addr,
    output logic                      stall,
    output logic                      issue_fire,
    output logic [NRD-1:0][SELW-1:0]  fwd_sel_ex,
    output logic                      busy
);

    localparam logic [SB_W-1:0] LAT_MAX = SB_W'(DEPTH - 1);

    logic [SB_W-1:0]               lat_in;
    logic [SB_W-1:0]               lat_norm;
    sb_entry_t                     ent [NREGS];
    logic [NREGS-1:0]              live;
    logic [NRD-1:0]                haz;
    logic [NRD-1:0][SB_W-1:0]      src_age;
    logic [NRD-1:0][SB_W-1:0]      src_lat;
    logic [NRD-1:0][SELW-1:0]      fwd_nxt;

    // Out-of-range latencies fall back to the slowest forwardable result
    assign lat_in   = SB_W'(issue_lat);
    assign lat_norm = (lat_in == '0 || lat_in > LAT_MAX) ? LAT_MAX : lat_in;

    assign ent[0]  = '0;
    assign live[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_ent
        sb_entry #(.DEPTH(DEPTH)) u_ent (
            .clk     (clk),
            .rst     (rst),
            .set     (issue_fire && issue_wr && (issue_rd == AW'(r))),
            .set_lat (lat_norm),
            .ent     (ent[r])
        );
        assign live[r] = (ent[r].age != '0);
    end

    // Checks read the pre-issue state, so a self-dependent instruction sees the older writer
    for (genvar p = 0; p < NRD; p++) begin : g_port
        assign src_age[p] = ent[rs_addr[p]].age;
        assign src_lat[p] = ent[rs_addr[p]].lat;
        assign haz[p]     = rs_used[p] && (rs_addr[p] != '0) &&
                            (src_age[p] != '0) && (src_age[p] < src_lat[p]);
        assign fwd_nxt[p] = SELW'(fwd_from_age(int'(src_age[p]), DEPTH));
    end

    assign stall      = issue_valid && !flush && (|haz);
    assign issue_fire = issue_valid && !stall && !flush;
    assign busy       = |live;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_sel_ex <= '0;
        end else if (issue_fire) begin
            fwd_sel_ex <= fwd_nxt;
        end else begin
            fwd_sel_ex <= '0;
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and forwarding-select unit for the segmented RISC-V core. It replaces the fixed load-use stall check and the two-source forwarding logic with a per-register scoreboard that supports:
- configurable pipeline depth;
- any number of read ports;
- per-instruction result latency, e.g. ALU, load or multi-cycle multiply.

It sits beside decode. It decides stalls for the instruction in DE and registers the forwarding selects the operand muxes use in EX.

## Interface
Parameters:
- NREGS, 32: architectural registers; register 0 is never tracked.
- NRD, 2: read ports checked per instruction.
- DEPTH, 3: stages after DE (EX=1, ME=2, WB=3).
- AW, $clog2(NREGS): register address width.
- SELW, $clog2(DEPTH): forward-select width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  DE holds a valid instruction.
- issue_wr  in  1  the DE instruction writes a register.
- issue_rd  in  AW  destination register.
- issue_lat  in  SELW  result latency L; legal range 1..DEPTH-1 (ALU=1, load=2).
- flush  in  1  taken branch in EX; the DE instruction is discarded.
- rs_used  in  NRD  per-port operand-used flag.
- rs_addr  in  NRD×AW  per-port source register.
- stall  out  1  combinational; hold PC and DE, inject a bubble into EX.
- issue_fire  out  1  combinational; the DE instruction enters EX this edge.
- fwd_sel_ex  out  NRD×SELW  registered; 0 = register file, k = stage k+1 (1 = ME, 2 = WB, …).
- busy  out  1  any register tracked.

## Operation
- Per-register state:
  - age[r], 0..DEPTH: 0 means free; otherwise the current stage index of the youngest writer.
  - lat[r]: that writer's L.
- Aging: every cycle, each nonzero age increments. An entry at age DEPTH clears to 0 (retired).
- Issue rule: issue_fire = issue_valid & ~stall & ~flush.
  - On issue_fire with issue_wr and issue_rd≠0: age[issue_rd] is set to 1 and lat[issue_rd] to issue_lat.
  - This overrides the aging of that entry (WAW: the youngest writer wins).
- Hazard per port p, active when rs_used[p] and rs_addr[p]≠0. With a = age[rs], L = lat[rs]:
  - stall when 1 ≤ a < L, i.e. the result is not forwardable when the consumer reaches EX.
- stall is the OR over all ports, gated by issue_valid. flush forces stall=0.
- Hazard checks use pre-issue state. An instruction reading its own rd sees the previous writer.
- Forward select: on issue_fire, fwd_sel_ex[p] ← a if 1 ≤ a ≤ DEPTH-1, else 0. Otherwise fwd_sel_ex ← 0 (bubble).
- A producer at age DEPTH (in WB) at DE time selects 0. The register file is write-through, so the read returns the new value.
- Illegal issue_lat (0 or ≥DEPTH) is treated as DEPTH-1.

## Timing
- Reset: all ages 0; fwd_sel_ex=0; stall=0; busy=0. Reset is asynchronous and may occur mid-stall; the first cycle after reset has no hazards.
- Stall latency: 0 cycles, combinational from rs_addr and state.
- Load-use (L=2, consumer immediately behind): exactly 1 stall cycle.
- L-cycle producer followed immediately by a consumer: L-1 stall cycles.
- fwd_sel_ex is valid in the cycle the consumer is in EX, one edge after issue_fire.
- flush and a hazard in the same cycle: no stall, no issue. In-flight entries keep aging; only DE is killed.
- Stage behind DE never stall, so aging never pauses.

## Structure
- Package hazard_pkg holds:
  - stage index constants (ST_EX, ST_ME, ST_WB);
  - the fwd_sel encoding;
  - typedef sb_entry_t {age, lat}.
- Sub-module sb_entry: one register's age/lat state and its aging/overwrite logic, instantiated NREGS-1 times through generate.
- Top level holds:
  - the NRD hazard comparators;
  - the stall reduction;
  - the fwd_sel_ex registers.

## Test plan
- ALU then dependent ALU: issue x5 (L=1), then read x5 → stall=0 throughout; fwd_sel_ex=1 (ME).
- Load-use: issue x6 (L=2), then read x6 → stall=1 for 1 cycle, then issue; fwd_sel_ex=2 (WB).
- Gap of 2: x7 producer, independent instruction, then read x7 → no stall; fwd_sel_ex=0 (write-through).
- WAW plus flush:
  - load x8, then ALU x8 (L=1), then read x8 → no stall; fwd_sel=1.
  - With flush=1 on a stalled load-use cycle → stall=0, issue_fire=0.
- Deep config, DEPTH=5, L=4 multiply x9 with immediate consumer → 3 stall cycles, then fwd_sel_ex=4.
- Reset asserted during a load-use stall → stall, busy and fwd_sel_ex go 0 asynchronously. After release, a read of x6 issues without stall.
